alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle initiator that drives the combinational 8-bit ALU: accepts a command under a
//  Start/Busy/Done handshake and issues one ALU op per cycle, collecting AluOut into a
//  result. Sits between the controller and the ALU for ops the ALU lacks (low-byte MUL, N-bit shifts).
// PARAMETERS
//  W         8    data width; must equal ALU width
//  CNT_W     3    iteration counter width, log2(W)
// PORTS
//  Clk         in   1    clock, rising edge
//  Reset       in   1    asynchronous, active-high reset
//  Start       in   1    command request; sampled only in IDLE
//  Cmd         in   2    00 SINGLE, 01 MUL, 10 SHIFTN, 11 reserved
//  OpSel       in   4    ALU opcode for SINGLE
//  OperandA    in   W    operand A / multiplicand / shift source
//  OperandB    in   W    operand B / multiplier / [3]=dir(1=right),[2:0]=N
//  Busy        out  1    high in every state except IDLE and DONE
//  Done        out  1    one-cycle pulse; Result valid from this cycle
//  Result      out  W    registered result; holds until the next Done
//  ResultZero  out  1    registered (Result==0)
//  AluA,AluB   out  W    ALU operands
//  AluOp       out  4    ALU opcode
//  AluOut      in   W    ALU result
//  AluZero     in   1    ALU zero flag (unused except SINGLE debug)
// BEHAVIOUR
//  Reset: state=IDLE; Busy=0, Done=0, Result=0, ResultZero=1; AluA=AluB=0, AluOp=OP_NOP.
//  Reset mid-operation aborts immediately; no Done is produced for the aborted command.
//  In IDLE and DONE, the ALU outputs are driven AluA=AluB=0, AluOp=OP_NOP (4'b1111).
//  Start in IDLE at edge 0: capture operands, go to the first state; Start at any other time is ignored.
//  States: IDLE, EXEC, MUL_ADD, MUL_SHL, SHIFT, DONE. DONE always returns to IDLE next cycle.
//  SINGLE: EXEC drives OperandA/OperandB/OpSel. Result<=AluOut. Done in cycle 2.
//  MUL (low byte, mod 2^W): acc=0, mcand=A, mplr=B, cnt=0.
//   MUL_ADD drives AluA=acc, AluB=mcand, ADD.
//    If mplr[0], acc<=AluOut. Then mplr>>=1 locally and cnt++.
//    If cnt==W-1, go to DONE; otherwise go to MUL_SHL.
//   MUL_SHL drives AluA=mcand, SHL; mcand<=AluOut; go to MUL_ADD.
//   Fixed latency: 8 ADD + 7 SHL cycles, so Done in cycle 16.
//  SHIFTN: N=OperandB[2:0]. N==0 goes straight to DONE with Result=OperandA (Done cycle 1).
//   Otherwise N SHIFT cycles run, each with AluA=work and AluOp=SHL or SHR (by dir); work<=AluOut.
//   Done in cycle N+1.
//  Reserved Cmd: one EXEC cycle with OP_NOP; Result=0, ResultZero=1; Done in cycle 2.
//  Result/ResultZero update only on the transition into DONE.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined: in MUL_ADD, if the post-shift mplr==0, go to DONE regardless of cnt.
//   Latency then depends on data; B=0 gives Done in cycle 2.
//  MUL_EARLY_EXIT_EN undefined: fixed MUL latency as above (Done cycle 16).
// STRUCTURE
//  Package alu_seq_pkg: ALU opcode constants, Cmd enum, state enum.
//   Opcodes: OP_ADD=4'b0000, OP_SUB=4'b1010, OP_XOR=4'b0010, OP_SHL=4'b0100, OP_SHR=4'b1101,
//   OP_NOP=4'b1111.
//  Single flat module; no sub-module.
//  One registered state machine, with combinational ALU-drive decode from state.
// TESTING
//  Edge 0 is the Start edge; cycle k is k edges later.
//  1 SINGLE OP_ADD A=0x7F B=0x01 -> Done@2, Result=0x80, ResultZero=0.
//    SINGLE OP_SUB A=0x05 B=0x05 -> Result=0x00, ResultZero=1.
//  2 MUL A=13 B=11 -> Result=0x8F. Without EN: Done@16, Busy high cycles 1-15.
//    MUL A=0x10 B=0x10 -> Result=0x00, ResultZero=1 (wrap).
//  3 MUL_EARLY_EXIT_EN, MUL A=5 B=3 -> Result=0x0F, Done@4.
//    MUL_EARLY_EXIT_EN, MUL A=0x2A B=0 -> Result=0, Done@2.
//  4 SHIFTN A=0x80 B=0x0F (right, N=7) -> Result=0x01, Done@8.
//    SHIFTN A=0x81 B=0x01 -> Result=0x02.
//    SHIFTN A=0x5A B=0x00 -> Result=0x5A, Done@1.
//  5 Start pulsed again at cycle 3 of a MUL -> ignored; a single Done and an unchanged result.
//    Start held high through DONE -> next command accepted only in IDLE.
//  6 Reset asserted mid-cycle during MUL -> Busy=0, Result=0, AluOp=OP_NOP with no edge needed.
//    After release, SINGLE OP_XOR A=0xF0 B=0xFF -> Result=0x0F, Done@2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, command codes and sequencer states for alu_seq_ctrl.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        CmdSingle = 2'b00,
        CmdMul    = 2'b01,
        CmdShiftN = 2'b10,
        CmdRsvd   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMulAdd,
        StMulShl,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving an external combinational ALU (single op, low-byte MUL, N-bit shift).
// Optional MUL_EARLY_EXIT_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [1:0]   Cmd,
    input  logic [3:0]   OpSel,
    input  logic [W-1:0] OperandA,
    input  logic [W-1:0] OperandB,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Result,
    output logic         ResultZero,
    output logic [W-1:0] AluA,
    output logic [W-1:0] AluB,
    output logic [3:0]   AluOp,
    input  logic [W-1:0] AluOut,
    input  logic         AluZero
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(W - 1);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [3:0]         opsel_q, opsel_d;
    logic [W-1:0]       acc_q, acc_d;
    // mcand doubles as operand A for SINGLE and as the shift work register.
    logic [W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]       mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [W-1:0]       result_q, result_d;
    logic               result_zero_q;
    logic [W-1:0]       acc_add;
    logic               mul_last;
    logic               unused_alu_zero;

    assign unused_alu_zero = AluZero;
    assign acc_add = mplr_q[0] ? AluOut : acc_q;

`ifdef MUL_EARLY_EXIT_EN
    assign mul_last = (cnt_q == CntLast) || (mplr_q[W-1:1] == '0);
`else
    assign mul_last = (cnt_q == CntLast);
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        opsel_d  = opsel_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        AluA     = '0;
        AluB     = '0;
        AluOp    = OP_NOP;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    cmd_d   = cmd_e'(Cmd);
                    opsel_d = OpSel;
                    acc_d   = '0;
                    mcand_d = OperandA;
                    mplr_d  = OperandB;
                    cnt_d   = '0;
                    dir_d   = OperandB[CNT_W];
                    case (cmd_e'(Cmd))
                        CmdMul:    state_d = StMulAdd;
                        CmdShiftN: begin
                            if (OperandB[CNT_W-1:0] == '0) begin
                                state_d  = StDone;
                                result_d = OperandA;
                            end else begin
                                state_d = StShift;
                                cnt_d   = OperandB[CNT_W-1:0];
                            end
                        end
                        default:   state_d = StExec;
                    endcase
                end
            end
            StExec: begin
                if (cmd_q == CmdSingle) begin
                    AluA     = mcand_q;
                    AluB     = mplr_q;
                    AluOp    = opsel_q;
                    result_d = AluOut;
                end else begin
                    result_d = '0;
                end
                state_d = StDone;
            end
            StMulAdd: begin
                AluA   = acc_q;
                AluB   = mcand_q;
                AluOp  = OP_ADD;
                acc_d  = acc_add;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (mul_last) begin
                    state_d  = StDone;
                    result_d = acc_add;
                end else begin
                    state_d = StMulShl;
                end
            end
            StMulShl: begin
                AluA    = mcand_q;
                AluOp   = OP_SHL;
                mcand_d = AluOut;
                state_d = StMulAdd;
            end
            StShift: begin
                AluA    = mcand_q;
                AluOp   = dir_q ? OP_SHR : OP_SHL;
                mcand_d = AluOut;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = StDone;
                    result_d = AluOut;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= StIdle;
            cmd_q         <= CmdSingle;
            opsel_q       <= OP_NOP;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplr_q        <= '0;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            opsel_q       <= opsel_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplr_q        <= mplr_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            result_q      <= result_d;
            result_zero_q <= (result_d == '0);
        end
    end

    assign Busy       = !(state_q inside {StIdle, StDone});
    assign Done       = (state_q == StDone);
    assign Result     = result_q;
    assign ResultZero = result_zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised self-checking bench for alu_seq_ctrl with a behavioural ALU and result/latency model.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [3:0] opsel;
    logic [7:0] opa, opb;
    logic       busy, done;
    logic [7:0] result;
    logic       result_zero;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_op;
    logic       alu_zero;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl #(.W(8), .CNT_W(3)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Cmd(cmd), .OpSel(opsel),
        .OperandA(opa), .OperandB(opb), .Busy(busy), .Done(done), .Result(result),
        .ResultZero(result_zero), .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op),
        .AluOut(alu_out), .AluZero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return {a[6:0], 1'b0};
            OP_SHR:  return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out  = alu_ref(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_out == 8'h00);

    function automatic logic [7:0] exp_result(input logic [1:0] c, input logic [3:0] op,
                                              input logic [7:0] a, b);
        logic [15:0] prod;
        logic [7:0]  sh;
        case (c)
            2'b00: return alu_ref(op, a, b);
            2'b01: begin
                prod = a * b;
                return prod[7:0];
            end
            2'b10: begin
                sh = b[3] ? (a >> b[2:0]) : (a << b[2:0]);
                return sh;
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] c, input logic [7:0] b);
        int n;
        n = 0;
        case (c)
            2'b01: begin
`ifdef MUL_EARLY_EXIT_EN
                for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
                if (n == 0) n = 1;
                return 2 * n;
`else
                return 16;
`endif
            end
            2'b10:   return int'(b[2:0]) + 1;
            default: return 2;
        endcase
    endfunction

    // Issues one command and reports Done latency, result, and handshake sanity.
    task automatic run_cmd(input logic [1:0] c, input logic [3:0] op, input logic [7:0] a, b,
                           output int lat, output logic [7:0] res, output logic rz,
                           output bit hs_ok, output logic [3:0] done_op);
        lat   = 0;
        hs_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; cmd = c; opsel = op; opa = a; opb = b;
        @(posedge clk);
        #1;
        start = 1'b0; cmd = 2'($urandom); opsel = 4'($urandom);
        opa = 8'($urandom); opb = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) hs_ok = 1'b0;
        end
        res     = result;
        rz      = result_zero;
        done_op = alu_op;
        if (busy) hs_ok = 1'b0;
        @(negedge clk);
        if (done || busy) hs_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cmd = 2'b00; opsel = 4'h0; opa = 8'h00; opb = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (result !== 8'h00 || result_zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_result: got %h/%b want 00/1", result, result_zero);
        end
        total++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== OP_NOP) begin
            bad++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h want 00 00 f", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single;
        logic [3:0] ops [5];
        logic [3:0] op, dop;
        logic [7:0] a, b, res, er;
        logic       rz;
        int         lat;
        bit         ok;
        ops = '{OP_ADD, OP_SUB, OP_XOR, OP_SHL, OP_SHR};
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      begin op = OP_ADD; a = 8'h7F; b = 8'h01; end
            else if (i == 1) begin op = OP_SUB; a = 8'h05; b = 8'h05; end
            else begin
                op = ops[$urandom_range(0, 4)]; a = 8'($urandom); b = 8'($urandom);
            end
            run_cmd(2'b00, op, a, b, lat, res, rz, ok, dop);
            er = exp_result(2'b00, op, a, b);
            total++;
            if (res !== er) begin
                bad++;
                $display("FAIL single_result op=%h a=%h b=%h: got %h want %h", op, a, b, res, er);
            end
            total++;
            if (rz !== (er == 8'h00)) begin
                bad++;
                $display("FAIL single_zero: got %b want %b", rz, (er == 8'h00));
            end
            total++;
            if (lat !== 2) begin
                bad++;
                $display("FAIL single_latency: got %0d want 2", lat);
            end
            total++;
            if (!ok || dop !== OP_NOP) begin
                bad++;
                $display("FAIL single_handshake: ok=%b done_op=%h want 1 f", ok, dop);
            end
        end
    endtask

    task automatic test_mul;
        logic [3:0] dop;
        logic [7:0] a, b, res, er;
        logic       rz;
        int         lat, el;
        bit         ok;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:       begin a = 8'd13;  b = 8'd11;  end
                1:       begin a = 8'h10;  b = 8'h10;  end
                2:       begin a = 8'd5;   b = 8'd3;   end
                3:       begin a = 8'h2A;  b = 8'h00;  end
                4:       begin a = 8'hFF;  b = 8'h80;  end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            run_cmd(2'b01, 4'h0, a, b, lat, res, rz, ok, dop);
            er = exp_result(2'b01, 4'h0, a, b);
            el = exp_lat(2'b01, b);
            total++;
            if (res !== er) begin
                bad++;
                $display("FAIL mul_result a=%h b=%h: got %h want %h", a, b, res, er);
            end
            total++;
            if (rz !== (er == 8'h00)) begin
                bad++;
                $display("FAIL mul_zero: got %b want %b", rz, (er == 8'h00));
            end
            total++;
            if (lat !== el) begin
                bad++;
                $display("FAIL mul_latency b=%h: got %0d want %0d", b, lat, el);
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL mul_handshake: busy/done got bad want ok");
            end
        end
    endtask

    task automatic test_shiftn;
        logic [3:0] dop;
        logic [7:0] a, b, res, er;
        logic       rz;
        int         lat, el;
        bit         ok;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:       begin a = 8'h80; b = 8'h0F; end
                1:       begin a = 8'h81; b = 8'h01; end
                2:       begin a = 8'h5A; b = 8'h00; end
                3:       begin a = 8'h01; b = 8'h07; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            run_cmd(2'b10, 4'h0, a, b, lat, res, rz, ok, dop);
            er = exp_result(2'b10, 4'h0, a, b);
            el = exp_lat(2'b10, b);
            total++;
            if (res !== er) begin
                bad++;
                $display("FAIL shift_result a=%h b=%h: got %h want %h", a, b, res, er);
            end
            total++;
            if (rz !== (er == 8'h00)) begin
                bad++;
                $display("FAIL shift_zero: got %b want %b", rz, (er == 8'h00));
            end
            total++;
            if (lat !== el) begin
                bad++;
                $display("FAIL shift_latency b=%h: got %0d want %0d", b, lat, el);
            end
            total++;
            if (!ok && el > 1) begin
                bad++;
                $display("FAIL shift_handshake: busy/done got bad want ok");
            end
        end
    endtask

    task automatic test_reserved;
        logic [3:0] dop;
        logic [7:0] res;
        logic       rz;
        int         lat;
        bit         ok;
        run_cmd(2'b00, OP_ADD, 8'h11, 8'h22, lat, res, rz, ok, dop);
        run_cmd(2'b11, OP_ADD, 8'($urandom), 8'($urandom), lat, res, rz, ok, dop);
        total++;
        if (res !== 8'h00 || rz !== 1'b1 || lat !== 2) begin
            bad++;
            $display("FAIL reserved: got res=%h z=%b lat=%0d want 00 1 2", res, rz, lat);
        end
    endtask

    task automatic test_start_ignored;
        int         ndone, first;
        logic [7:0] res;
        ndone = 0; first = 0; res = 8'h00;
        @(negedge clk);
        start = 1'b1; cmd = 2'b01; opa = 8'd13; opb = 8'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1; cmd = 2'b00; opsel = OP_ADD; opa = 8'h01; opb = 8'h01;
            end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first = k;
                    res = result;
                end
            end
        end
        total++;
        if (ndone !== 1 || first !== exp_lat(2'b01, 8'd11)) begin
            bad++;
            $display("FAIL start_ignored_done: got n=%0d at %0d want 1 at %0d", ndone, first,
                     exp_lat(2'b01, 8'd11));
        end
        total++;
        if (res !== 8'h8F || result !== 8'h8F) begin
            bad++;
            $display("FAIL start_ignored_result: got %h/%h want 8f", res, result);
        end
    endtask

    task automatic test_back_to_back;
        int         ndone, d1, d2;
        logic [7:0] r1, r2;
        ndone = 0; d1 = 0; d2 = 0; r1 = 8'h00; r2 = 8'h00;
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; opsel = OP_ADD; opa = 8'h21; opb = 8'h34;
        @(posedge clk);
        #1;
        opsel = OP_XOR; opa = 8'hC3; opb = 8'h5A;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = k; r1 = result; end
                if (ndone == 2) begin d2 = k; r2 = result; end
            end
        end
        total++;
        if (ndone !== 2 || d1 !== 2 || d2 !== 5) begin
            bad++;
            $display("FAIL held_start_timing: got n=%0d d1=%0d d2=%0d want 2 2 5", ndone, d1, d2);
        end
        total++;
        if (r1 !== 8'h55 || r2 !== 8'h99) begin
            bad++;
            $display("FAIL held_start_results: got %h %h want 55 99", r1, r2);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] dop;
        logic [7:0] res;
        logic       rz;
        int         lat, spurious;
        bit         ok;
        run_cmd(2'b00, OP_ADD, 8'h01, 8'h02, lat, res, rz, ok, dop);
        @(negedge clk);
        start = 1'b1; cmd = 2'b01; opa = 8'd13; opb = 8'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hs: busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (result !== 8'h00 || result_zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_result: got %h/%b want 00/1", result, result_zero);
        end
        total++;
        if (alu_op !== OP_NOP || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_alu: got op=%h a=%h b=%h want f 00 00", alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL reset_mid_abort: got %0d active cycles want 0", spurious);
        end
        run_cmd(2'b00, OP_XOR, 8'hF0, 8'hFF, lat, res, rz, ok, dop);
        total++;
        if (res !== 8'h0F || rz !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL reset_mid_xor: got res=%h z=%b lat=%0d want 0f 0 2", res, rz, lat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_shiftn();
        test_reserved();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
